hqm_devtlb_rstgen: RTL and testbench

Local reset generator for the devtlb clock domain, and the producing end of the reset path that the devtlb reset muxes consume.
- Asserts `reset_out_b` asynchronously and releases it synchronously.
- Services a synchronous soft-reset request: waits for downstream idle, holds reset for a fixed pulse width, then acknowledges.
- The output passes through a scan-bypass mux, so DFT controls reset directly in scan mode.

---
 rtl/hqm_devtlb_pkg.sv | 21 ++
 rtl/hqm_devtlb_rstgen_if.sv | 29 ++
 rtl/hqm_devtlb_ctech_mux_2to1.sv | 15 +
 rtl/hqm_devtlb_rst_sync.sv | 27 ++
 rtl/hqm_devtlb_rstgen.sv | 104 ++++++++++
 tb/tb_hqm_devtlb_rstgen.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/hqm_devtlb_pkg.sv
// rtl/hqm_devtlb_pkg.sv - shared types for the devtlb reset generator
//
// Purpose: state encoding and small helpers used by hqm_devtlb_rstgen.
// Ports: none (package).

package hqm_devtlb_pkg;

  typedef enum logic [2:0] {
    RESET = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } rstgen_state_t;

  // States in which the generated reset is released (high).
  function automatic logic rst_released(rstgen_state_t s);
    return (s == RUN) || (s == DRAIN) || (s == ACK);
  endfunction

endpackage

// File: rtl/hqm_devtlb_rstgen_if.sv
// rtl/hqm_devtlb_rstgen_if.sv - soft-reset request/acknowledge interface
//
// Purpose: groups the soft-reset handshake between a requester and the rstgen.
// Signals: req_rst (one-cycle request), idle (downstream quiescent),
//          rst_ack (one-cycle completion pulse), rst_active (rstgen not in RUN).
// Modports: master = requester side, slave = reset generator side.

interface hqm_devtlb_rstgen_if;

  logic req_rst;
  logic idle;
  logic rst_ack;
  logic rst_active;

  modport master (
    output req_rst,
    output idle,
    input  rst_ack,
    input  rst_active
  );

  modport slave (
    input  req_rst,
    input  idle,
    output rst_ack,
    output rst_active
  );

endinterface

// File: rtl/hqm_devtlb_ctech_mux_2to1.sv
// rtl/hqm_devtlb_ctech_mux_2to1.sv - 2:1 mux cell wrapper for reset/scan paths
//
// Purpose: single instantiable mux cell so reset muxing maps to one library cell.
// Ports: d0 (selected when s=0), d1 (selected when s=1), s (select), o (output).

module hqm_devtlb_ctech_mux_2to1 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic o
);

  assign o = s ? d1 : d0;

endmodule

// File: rtl/hqm_devtlb_rst_sync.sv
// rtl/hqm_devtlb_rst_sync.sv - reset deassertion synchronizer
//
// Purpose: asserts sync_b asynchronously with clr_b and releases it
//          SYNC_STAGES clk edges after clr_b rises.
// Ports: clk (clock), clr_b (async active-low clear), sync_b (synchronized release).

module hqm_devtlb_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_b,
  output logic sync_b
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_b = chain[SYNC_STAGES-1];

endmodule

// File: rtl/hqm_devtlb_rstgen.sv
// rtl/hqm_devtlb_rstgen.sv - devtlb local reset generator with soft reset and scan bypass
//
// Purpose: async-assert / sync-release reset for the devtlb domain; services a
//          soft-reset request (drain, fixed-width pulse, acknowledge).
// Ports: clk, clr_b (async active-low reset in), rst_bypass_b / rst_bypass_sel
//        (scan reset value / scan select), reset_out_b (generated reset),
//        rg (slave side of the req_rst/idle/rst_ack/rst_active handshake).

module hqm_devtlb_rstgen
  import hqm_devtlb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                clr_b,
  input  logic                rst_bypass_b,
  input  logic                rst_bypass_sel,
  output logic                reset_out_b,
  hqm_devtlb_rstgen_if.slave  rg
);

  logic          arst_b;
  logic          sync_b;
  rstgen_state_t state;
  rstgen_state_t next_state;
  logic [CNT_W-1:0] cnt;
  logic          rst_int_b;
  logic          ack_q;
  logic          active_q;

  // In scan mode DFT owns the reset of every flop in this block.
  hqm_devtlb_ctech_mux_2to1 u_arst_mux (
    .d0 (clr_b),
    .d1 (rst_bypass_b),
    .s  (rst_bypass_sel),
    .o  (arst_b)
  );

  hqm_devtlb_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .clr_b  (arst_b),
    .sync_b (sync_b)
  );

  always_ff @(posedge clk or negedge arst_b) begin
    if (!arst_b) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  // Requests outside RUN are simply not looked at, which drops them.
  always_comb begin
    next_state = state;
    case (state)
      RESET: if (sync_b)       next_state = RUN;
      RUN:   if (rg.req_rst)   next_state = DRAIN;
      DRAIN: if (rg.idle)      next_state = HOLD;
      HOLD:  if (cnt == '0)    next_state = ACK;
      ACK:                     next_state = RUN;
      default:                 next_state = RESET;
    endcase
  end

  // Loaded on HOLD entry so the pulse spans exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk or negedge arst_b) begin
    if (!arst_b) begin
      cnt <= '0;
    end else if ((state != HOLD) && (next_state == HOLD)) begin
      cnt <= CNT_W'(HOLD_CYCLES - 1);
    end else if ((state == HOLD) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Outputs are registered from next_state so none is a decode of state bits.
  always_ff @(posedge clk or negedge arst_b) begin
    if (!arst_b) begin
      rst_int_b <= 1'b0;
      ack_q     <= 1'b0;
      active_q  <= 1'b1;
    end else begin
      rst_int_b <= rst_released(next_state);
      ack_q     <= (next_state == ACK);
      active_q  <= (next_state != RUN);
    end
  end

  hqm_devtlb_ctech_mux_2to1 u_out_mux (
    .d0 (rst_int_b),
    .d1 (rst_bypass_b),
    .s  (rst_bypass_sel),
    .o  (reset_out_b)
  );

  assign rg.rst_ack    = ack_q;
  assign rg.rst_active = active_q;

endmodule

// File: tb/tb_hqm_devtlb_rstgen.sv
// tb/tb_hqm_devtlb_rstgen.sv - self-checking bench for hqm_devtlb_rstgen

module tb_hqm_devtlb_rstgen;
  import hqm_devtlb_pkg::*;

  localparam int S = 2;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_b          = 1'b1;
  logic rst_bypass_b   = 1'b1;
  logic rst_bypass_sel = 1'b0;
  logic reset_out_b;

  hqm_devtlb_rstgen_if rg ();

  hqm_devtlb_rstgen #(
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H)
  ) dut (
    .clk            (clk),
    .clr_b          (clr_b),
    .rst_bypass_b   (rst_bypass_b),
    .rst_bypass_sel (rst_bypass_sel),
    .reset_out_b    (reset_out_b),
    .rg             (rg)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: timeline arithmetic on the count of edges since the effective
  // reset released. Soft reset tracked as the edge the request was taken
  // and the edge the HOLD window opened.
  logic arst_m;
  assign arst_m = rst_bypass_sel ? rst_bypass_b : clr_b;

  int m_e    = 0;
  int req_e  = -1;
  int hold_s = -1;

  always @(posedge clk or negedge arst_m) begin
    if (!arst_m) begin
      m_e    <= 0;
      req_e  <= -1;
      hold_s <= -1;
    end else begin
      int  ne;
      bit  was_run;
      was_run = (m_e >= S + 1) && (req_e < 0);
      ne      = m_e + 1;
      if ((hold_s >= 0) && (ne == hold_s + H + 1)) begin
        req_e  <= -1;
        hold_s <= -1;
      end else if ((req_e >= 0) && (hold_s < 0) && rg.idle) begin
        hold_s <= ne;
      end
      if (was_run && rg.req_rst) req_e <= ne;
      m_e <= ne;
    end
  end

  logic m_out, m_ack, m_act;
  always_comb begin
    m_out = (m_e >= S + 1) &&
            !((hold_s >= 0) && (m_e >= hold_s) && (m_e <= hold_s + H - 1));
    m_ack = (hold_s >= 0) && (m_e == hold_s + H);
    m_act = (m_e < S + 1) || (req_e >= 0);
  end

  always @(negedge clk) begin
    chk("cyc_reset_out_b", reset_out_b, rst_bypass_sel ? rst_bypass_b : m_out);
    chk("cyc_rst_ack", rg.rst_ack, m_ack);
    chk("cyc_rst_active", rg.rst_active, m_act);
  end

  task automatic run_to(input int k);
    int g = 0;
    while ((m_e != k) && (g < 200)) begin
      @(negedge clk);
      g++;
    end
    if (m_e != k) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to: edge count %0d, wanted %0d", m_e, k);
    end
  endtask

  initial begin
    rg.req_rst = 1'b0;
    rg.idle    = 1'b1;
    #1 clr_b = 1'b0;

    // Power-up
    repeat (5) @(negedge clk);
    chk("rv_reset_out_b", reset_out_b, 1'b0);
    chk("rv_rst_ack", rg.rst_ack, 1'b0);
    chk("rv_rst_active", rg.rst_active, 1'b1);
    chk("rv_state", dut.state == RESET, 1'b1);
    #2 clr_b = 1'b1;
    run_to(2);
    chk("pu_e2_out", reset_out_b, 1'b0);
    chk("pu_e2_active", rg.rst_active, 1'b1);
    run_to(3);
    chk("pu_e3_out", reset_out_b, 1'b1);
    chk("pu_e3_active", rg.rst_active, 1'b0);

    // Soft reset with idle
    run_to(9);
    #2 rg.req_rst = 1'b1;
    run_to(10);
    chk("sr_e10_out", reset_out_b, 1'b1);
    chk("sr_e10_active", rg.rst_active, 1'b1);
    #2 rg.req_rst = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      run_to(k);
      chk("sr_hold_out", reset_out_b, 1'b0);
      chk("sr_hold_ack", rg.rst_ack, 1'b0);
    end
    run_to(19);
    chk("sr_e19_out", reset_out_b, 1'b1);
    chk("sr_e19_ack", rg.rst_ack, 1'b1);
    run_to(20);
    chk("sr_e20_ack", rg.rst_ack, 1'b0);
    chk("sr_e20_active", rg.rst_active, 1'b0);

    // Drain stall, then a dropped request during HOLD
    run_to(24);
    #2 rg.idle = 1'b0;
    rg.req_rst = 1'b1;
    run_to(25);
    #2 rg.req_rst = 1'b0;
    run_to(31);
    chk("dr_e31_out", reset_out_b, 1'b1);
    chk("dr_e31_active", rg.rst_active, 1'b1);
    #2 rg.idle = 1'b1;
    run_to(32);
    chk("dr_e32_out", reset_out_b, 1'b0);
    run_to(34);
    #2 rg.req_rst = 1'b1;
    run_to(35);
    #2 rg.req_rst = 1'b0;
    run_to(39);
    chk("dr_e39_out", reset_out_b, 1'b0);
    run_to(40);
    chk("dr_e40_out", reset_out_b, 1'b1);
    chk("dr_e40_ack", rg.rst_ack, 1'b1);
    run_to(41);
    chk("dr_e41_active", rg.rst_active, 1'b0);
    run_to(46);
    chk("dr_e46_out", reset_out_b, 1'b1);
    chk("dr_e46_active", rg.rst_active, 1'b0);

    // Async abort in the 4th HOLD cycle
    run_to(49);
    #2 rg.req_rst = 1'b1;
    run_to(50);
    #2 rg.req_rst = 1'b0;
    run_to(54);
    chk("ab_e54_out", reset_out_b, 1'b0);
    #3 clr_b = 1'b0;
    #1;
    chk("ab_async_out", reset_out_b, 1'b0);
    chk("ab_async_ack", rg.rst_ack, 1'b0);
    chk("ab_async_active", rg.rst_active, 1'b1);
    repeat (3) @(negedge clk);
    chk("ab_held_ack", rg.rst_ack, 1'b0);
    #2 clr_b = 1'b1;
    run_to(2);
    chk("ab_e2_out", reset_out_b, 1'b0);
    run_to(3);
    chk("ab_e3_out", reset_out_b, 1'b1);
    chk("ab_e3_active", rg.rst_active, 1'b0);

    // Scan bypass
    run_to(6);
    #2 rst_bypass_sel = 1'b1;
    #1;
    chk("sc_out_hi", reset_out_b, 1'b1);
    rst_bypass_b = 1'b0;
    #1;
    chk("sc_out_lo", reset_out_b, 1'b0);
    chk("sc_state_reset", dut.state == RESET, 1'b1);
    chk("sc_active", rg.rst_active, 1'b1);
    rst_bypass_b = 1'b1;
    #1;
    chk("sc_out_hi2", reset_out_b, 1'b1);
    rst_bypass_b = 1'b0;
    #1;
    chk("sc_out_lo2", reset_out_b, 1'b0);
    repeat (2) @(negedge clk);
    chk("sc_state_held", dut.state == RESET, 1'b1);
    #2 rst_bypass_sel = 1'b0;
    #1;
    chk("sc_func_out", reset_out_b, 1'b0);
    run_to(2);
    chk("sc_e2_out", reset_out_b, 1'b0);
    run_to(3);
    chk("sc_e3_out", reset_out_b, 1'b1);
    chk("sc_e3_active", rg.rst_active, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
